// File: rtl/sim_mem_stage.sv
// Terminal memory stage: multi-channel write, registered read,
// post-reset clear sequencer and a periodic word probe.
module sim_mem_stage #(
    parameter int DW           = 32,
    parameter int DEPTH        = 256,
    parameter int NCH          = 2,
    parameter int PROBE_ADDR   = 127,
    parameter int PROBE_PERIOD = 16,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    wr_valid,
    input  logic [NCH*AW-1:0] wr_addr,
    input  logic [NCH*DW-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              clear_busy,
    output logic              probe_valid,
    output logic [DW-1:0]     probe_data,
    output logic [31:0]       wr_count
);

    localparam int PW = (PROBE_PERIOD > 1) ? $clog2(PROBE_PERIOD) : 1;
    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PROBE_IDX  = AW'(PROBE_ADDR);
    localparam logic [PW-1:0] PROBE_LAST = PW'(PROBE_PERIOD - 1);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clear_idx_q, clear_idx_d;
    logic [PW-1:0]   probe_cnt_q, probe_cnt_d;
    logic [31:0]     wr_count_q, wr_count_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            probe_valid_q, probe_valid_d;
    logic [DW-1:0]   probe_data_q, probe_data_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic run;
    logic wr_active;
    logic rd_fire;
    logic probe_fire;

    assign run        = (state_q == S_RUN);
    assign wr_active  = run && (|wr_valid);
    assign rd_fire    = run && rd_en;
    assign probe_fire = wr_active && (probe_cnt_q == PROBE_LAST);

    always_comb begin
        state_d       = state_q;
        clear_idx_d   = clear_idx_q;
        probe_cnt_d   = probe_cnt_q;
        wr_count_d    = wr_count_q;
        rd_valid_d    = rd_fire;
        rd_data_d     = rd_data_q;
        probe_valid_d = probe_fire;
        probe_data_d  = probe_data_q;

        unique case (state_q)
            S_CLEAR: begin
                clear_idx_d = clear_idx_q + AW'(1);
                if (clear_idx_q == LAST_IDX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wr_active) begin
                    wr_count_d  = wr_count_q + 32'd1;
                    probe_cnt_d = probe_fire ? '0 : probe_cnt_q + PW'(1);
                end
            end
        endcase

        // Both samples take the array before this edge's writes land.
        if (rd_fire) begin
            rd_data_d = mem_q[rd_addr];
        end
        if (probe_fire) begin
            probe_data_d = mem_q[PROBE_IDX];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            clear_idx_q   <= '0;
            probe_cnt_q   <= '0;
            wr_count_q    <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            probe_valid_q <= 1'b0;
            probe_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            clear_idx_q   <= clear_idx_d;
            probe_cnt_q   <= probe_cnt_d;
            wr_count_q    <= wr_count_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            probe_valid_q <= probe_valid_d;
            probe_data_q  <= probe_data_d;
        end
    end

    // Later channels are applied last, so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                mem_q[clear_idx_q] <= '0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (wr_valid[i]) begin
                        mem_q[wr_addr[i*AW +: AW]] <= wr_data[i*DW +: DW];
                    end
                end
            end
        end
    end

    assign wr_ready    = run;
    assign clear_busy  = !run;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign probe_valid = probe_valid_q;
    assign probe_data  = probe_data_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_sim_mem_stage.sv
// Bench for sim_mem_stage: table vectors, directed corner sequences
// and random traffic against an array-based reference model.
module tb_sim_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_valid;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        clear_busy;
    logic        probe_valid;
    logic [31:0] probe_data;
    logic [31:0] wr_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sim_mem_stage dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .clear_busy  (clear_busy),
        .probe_valid (probe_valid),
        .probe_data  (probe_data),
        .wr_count    (wr_count)
    );

    // Reference model: memory array plus plain counters.
    bit          m_run;
    int          m_idx;
    logic [31:0] m_mem [256];
    int          m_pc;
    logic [31:0] m_wc;
    bit          m_rv;
    logic [31:0] m_rd;
    bit          m_pv;
    logic [31:0] m_pd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_run = 0;
            m_idx = 0;
            m_rv  = 0;
            m_rd  = 0;
            m_pv  = 0;
            m_pd  = 0;
            m_wc  = 0;
            m_pc  = 0;
        end else if (!m_run) begin
            m_mem[m_idx] = 32'h0;
            m_idx++;
            if (m_idx == 256) m_run = 1;
            m_rv = 0;
            m_pv = 0;
        end else begin
            m_rv = rd_en;
            if (rd_en) m_rd = m_mem[rd_addr];
            m_pv = 0;
            if (wr_valid != 2'b00) begin
                m_wc = m_wc + 1;
                m_pc = (m_pc + 1) % 16;
                if (m_pc == 0) begin
                    m_pv = 1;
                    m_pd = m_mem[127];
                end
                for (int c = 0; c < 2; c++) begin
                    if (wr_valid[c]) m_mem[wr_addr[c*8 +: 8]] = wr_data[c*32 +: 32];
                end
            end
        end
    endtask

    task automatic check_model();
        chk("m_wr_ready", {31'b0, wr_ready}, {31'b0, m_run});
        chk("m_clear_busy", {31'b0, clear_busy}, {31'b0, !m_run});
        chk("m_rd_valid", {31'b0, rd_valid}, {31'b0, m_rv});
        chk("m_rd_data", rd_data, m_rd);
        chk("m_probe_valid", {31'b0, probe_valid}, {31'b0, m_pv});
        chk("m_probe_data", probe_data, m_pd);
        chk("m_wr_count", wr_count, m_wc);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        wr_valid = 2'b00;
        wr_addr  = 16'h0;
        wr_data  = 64'h0;
        rd_en    = 1'b0;
        rd_addr  = 8'h0;
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (clear_busy === 1'b1 && n < 1000) begin
            cycle();
            n++;
        end
        chk("clear_len", n, 256);
        chk("wr_ready_after_clear", {31'b0, wr_ready}, 32'd1);
    endtask

    task automatic rd_one(input logic [7:0] a, input string name);
        rd_en   = 1'b1;
        rd_addr = a;
        cycle();
        rd_en = 1'b0;
        chk({name, "_rv"}, {31'b0, rd_valid}, 32'd1);
        chk(name, rd_data, 32'h0);
    endtask

    typedef struct {
        logic [1:0]  wv;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic        re;
        logic [7:0]  ra;
        logic        erv;
        logic [31:0] erd;
        logic [31:0] ewc;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{2'b11, 8'd5, 32'hDEADBEEF, 8'd200, 32'h12345678, 1'b0, 8'd0, 1'b0, 32'h0, 32'd1};
        tbl[1] = '{2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 1'b1, 8'd5, 1'b1, 32'hDEADBEEF, 32'd1};
        tbl[2] = '{2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 1'b1, 8'd200, 1'b1, 32'h12345678, 32'd1};
        tbl[3] = '{2'b11, 8'd9, 32'h1, 8'd9, 32'h2, 1'b0, 8'd0, 1'b0, 32'h12345678, 32'd2};
        tbl[4] = '{2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 1'b1, 8'd9, 1'b1, 32'h2, 32'd2};
        tbl[5] = '{2'b01, 8'd3, 32'hAA, 8'd0, 32'h0, 1'b0, 8'd0, 1'b0, 32'h2, 32'd3};
        tbl[6] = '{2'b10, 8'd0, 32'h0, 8'd3, 32'hBB, 1'b1, 8'd3, 1'b1, 32'hAA, 32'd4};
        tbl[7] = '{2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 1'b1, 8'd3, 1'b1, 32'hBB, 32'd4};
        tbl[8] = '{2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 1'b1, 8'd0, 1'b1, 32'h0, 32'd4};

        idle();
        reset = 1'b1;
        cycle();
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("rst_clear_busy", {31'b0, clear_busy}, 32'd1);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_probe_valid", {31'b0, probe_valid}, 32'd0);
        chk("rst_probe_data", probe_data, 32'h0);
        chk("rst_wr_count", wr_count, 32'h0);
        cycle();
        cycle();
        reset = 1'b0;
        wait_clear();

        rd_one(8'd0, "clr_rd0");
        rd_one(8'd127, "clr_rd127");
        rd_one(8'd255, "clr_rd255");
        cycle();
        chk("rd_valid_drop", {31'b0, rd_valid}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            wr_valid = tbl[i].wv;
            wr_addr  = {tbl[i].a1, tbl[i].a0};
            wr_data  = {tbl[i].d1, tbl[i].d0};
            rd_en    = tbl[i].re;
            rd_addr  = tbl[i].ra;
            cycle();
            chk($sformatf("tbl%0d_rv", i), {31'b0, rd_valid}, {31'b0, tbl[i].erv});
            chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].erd);
            chk($sformatf("tbl%0d_wc", i), wr_count, tbl[i].ewc);
        end
        idle();

        // Reset with writes pending on both channels.
        wr_valid = 2'b11;
        wr_addr  = {8'd7, 8'd5};
        wr_data  = {32'hCAFE0001, 32'hCAFE0002};
        reset    = 1'b1;
        cycle();
        chk("midrst_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("midrst_clear_busy", {31'b0, clear_busy}, 32'd1);
        chk("midrst_wr_count", wr_count, 32'h0);
        reset = 1'b0;
        idle();
        wait_clear();
        for (int a = 0; a < 256; a++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(a);
            cycle();
            chk($sformatf("midrst_rd%0d", a), rd_data, 32'h0);
        end
        idle();
        chk("midrst_wc_after", wr_count, 32'h0);

        wr_valid = 2'b01;
        wr_addr  = {8'd0, 8'd127};
        wr_data  = {32'h0, 32'h77};
        cycle();
        chk("probe_w1", {31'b0, probe_valid}, 32'd0);
        for (int k = 0; k < 15; k++) begin
            wr_addr = {8'd0, 8'(k)};
            wr_data = {32'h0, $urandom};
            cycle();
            if (k < 14) begin
                chk($sformatf("probe_quiet%0d", k + 2), {31'b0, probe_valid}, 32'd0);
            end else begin
                chk("probe_pulse", {31'b0, probe_valid}, 32'd1);
                chk("probe_data", probe_data, 32'h77);
            end
        end
        idle();
        cycle();
        chk("probe_one_shot", {31'b0, probe_valid}, 32'd0);
        chk("probe_hold", probe_data, 32'h77);

        for (int r = 0; r < 1500; r++) begin
            reset    = ($urandom_range(0, 399) == 0);
            wr_valid = 2'($urandom_range(0, 3));
            for (int c = 0; c < 2; c++) begin
                wr_addr[c*8 +: 8] = $urandom_range(0, 1) ?
                    8'($urandom_range(120, 135)) : 8'($urandom_range(0, 255));
                wr_data[c*32 +: 32] = $urandom;
            end
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = $urandom_range(0, 1) ?
                8'($urandom_range(120, 135)) : 8'($urandom_range(0, 255));
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
